// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset request generator and its sequencer bench:
// state encoding, default timing constants and counter types.
package reset_seq_pkg;

    localparam logic [1:0] ST_PULSE = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_FAIL  = 2'd3;

    typedef enum logic [1:0] {
        PULSE = ST_PULSE,
        WAIT  = ST_WAIT,
        RUN   = ST_RUN,
        FAIL  = ST_FAIL
    } seq_state_e;

    localparam int unsigned PULSE_LEN_DEF = 16;
    localparam int unsigned TIMEOUT_DEF   = 1024;
    localparam int unsigned LOSS_CYC_DEF  = 4;
    localparam int unsigned MAX_RETRY_DEF = 3;

    typedef logic [11:0] cnt_t;
    typedef logic [3:0]  loss_t;
    typedef logic [3:0]  retry_t;

endpackage

// File: rtl/rdy_loss_filter.sv
// Counts consecutive low cycles of iodelay_rdy; lost stays high once the
// count saturates at LOSS_CYC, until cleared or ready returns.
module rdy_loss_filter
    import reset_seq_pkg::*;
#(
    parameter int unsigned LOSS_CYC = LOSS_CYC_DEF
) (
    input  logic clk10m,
    input  logic sys_rst_n,
    input  logic iodelay_rdy,
    input  logic clr,
    output logic lost
);

    localparam loss_t LOSS_MAX = loss_t'(LOSS_CYC);

    loss_t count;

    // NOTE: registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk10m or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            count <= '0;
        end else if (clr || iodelay_rdy) begin
            count <= '0;
        end else if (count != LOSS_MAX) begin
            count <= count + 1'b1;
        end
    end

    assign lost = (count == LOSS_MAX);

endmodule

// File: rtl/reset_request_gen.sv
// Issues and supervises the active-low reset request to the reset sequencer:
// fixed pulse, completion watch, timeout retry, failure latch, ready-loss re-request.
module reset_request_gen
    import reset_seq_pkg::*;
#(
    parameter int unsigned PULSE_LEN = PULSE_LEN_DEF,
    parameter int unsigned TIMEOUT   = TIMEOUT_DEF,
    parameter int unsigned LOSS_CYC  = LOSS_CYC_DEF,
    parameter int unsigned MAX_RETRY = MAX_RETRY_DEF
) (
    input  logic         clk10m,
    input  logic         sys_rst_n,
    input  logic         sw_rst_req,
    input  logic         iodelay_rdy,
    input  logic         rst_pro,
    output logic         seq_rst_n,
    output logic         seq_done,
    output logic         seq_fail,
    output logic [3:0]   retry_cnt,
    output logic         loss_evt
);

    localparam cnt_t   PULSE_LAST   = cnt_t'(PULSE_LEN - 1);
    localparam cnt_t   TIMEOUT_LAST = cnt_t'(TIMEOUT - 1);
    localparam retry_t RETRY_LIMIT  = retry_t'(MAX_RETRY);

    seq_state_e state_q, state_d;
    cnt_t       cnt_q, cnt_d;
    retry_t     retry_d, retry_inc;
    logic       loss_evt_d;
    logic       lost;
    logic       loss_clr;

    // Counter is only live in RUN and is dropped on the edge that leaves it.
    assign loss_clr = (state_q != RUN) || (state_d != RUN);

    rdy_loss_filter #(
        .LOSS_CYC (LOSS_CYC)
    ) u_rdy_loss_filter (
        .clk10m      (clk10m),
        .sys_rst_n   (sys_rst_n),
        .iodelay_rdy (iodelay_rdy),
        .clr         (loss_clr),
        .lost        (lost)
    );

    assign retry_inc = retry_cnt + 1'b1;

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        retry_d    = retry_cnt;
        loss_evt_d = 1'b0;
        unique case (state_q)
            PULSE: begin
                if (sw_rst_req) begin
                    cnt_d = '0;
                end else if (cnt_q == PULSE_LAST) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                if (sw_rst_req) begin
                    state_d = PULSE;
                    cnt_d   = '0;
                end else if (!rst_pro) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    retry_d = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    retry_d = retry_inc;
                    cnt_d   = '0;
                    state_d = (retry_inc == RETRY_LIMIT) ? FAIL : PULSE;
                end
            end
            RUN: begin
                cnt_d = '0;
                if (sw_rst_req) begin
                    state_d = PULSE;
                end else if (rst_pro) begin
                    state_d = WAIT;
                end else if (lost) begin
                    state_d    = PULSE;
                    loss_evt_d = 1'b1;
                end
            end
            FAIL: begin
                cnt_d = '0;
                if (sw_rst_req) begin
                    state_d = PULSE;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = PULSE;
                cnt_d   = '0;
                retry_d = '0;
            end
        endcase
    end

    // Outputs are registered from the next state, so they track state_q exactly.
    always_ff @(posedge clk10m or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= PULSE;
            cnt_q     <= '0;
            seq_rst_n <= 1'b0;
            seq_done  <= 1'b0;
            seq_fail  <= 1'b0;
            retry_cnt <= '0;
            loss_evt  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            seq_rst_n <= (state_d != PULSE);
            seq_done  <= (state_d == RUN);
            seq_fail  <= (state_d == FAIL);
            retry_cnt <= retry_d;
            loss_evt  <= loss_evt_d;
        end
    end

endmodule

// File: tb/tb_reset_request_gen.sv
// Directed bench for reset_request_gen: pulse length, completion, timeout retry,
// failure latch, ready loss, software request and asynchronous board reset.
module tb_reset_request_gen;

    logic       clk10m;
    logic       sys_rst_n;
    logic       sw_rst_req;
    logic       iodelay_rdy;
    logic       rst_pro;
    logic       seq_rst_n;
    logic       seq_done;
    logic       seq_fail;
    logic [3:0] retry_cnt;
    logic       loss_evt;

    int total = 0;
    int bad   = 0;
    int len;
    int evts;

    reset_request_gen dut (
        .clk10m      (clk10m),
        .sys_rst_n   (sys_rst_n),
        .sw_rst_req  (sw_rst_req),
        .iodelay_rdy (iodelay_rdy),
        .rst_pro     (rst_pro),
        .seq_rst_n   (seq_rst_n),
        .seq_done    (seq_done),
        .seq_fail    (seq_fail),
        .retry_cnt   (retry_cnt),
        .loss_evt    (loss_evt)
    );

    initial clk10m = 1'b0;
    always #50 clk10m = ~clk10m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk10m);
    endtask

    // Counts consecutive negedges (starting now) with seq_rst_n low, bounded.
    task automatic measure_low(output int n, output int ev);
        n  = 0;
        ev = 0;
        while (seq_rst_n == 1'b0 && n < 5000) begin
            if (loss_evt) ev++;
            n++;
            @(negedge clk10m);
        end
    endtask

    initial begin
        sys_rst_n   = 1'b0;
        sw_rst_req  = 1'b0;
        iodelay_rdy = 1'b1;
        rst_pro     = 1'b1;
        tick(3);
        check("rst_seq_rst_n", seq_rst_n, 0);
        check("rst_seq_done", seq_done, 0);
        check("rst_seq_fail", seq_fail, 0);
        check("rst_retry", retry_cnt, 0);
        check("rst_loss_evt", loss_evt, 0);

        // Power-on pulse, then completion at cycle 400.
        sys_rst_n = 1'b1;
        measure_low(len, evts);
        check("por_pulse_len", len, 16);
        tick(384);
        check("wait_not_done", seq_done, 0);
        rst_pro = 1'b0;
        tick(1);
        check("run_done", seq_done, 1);
        check("run_retry", retry_cnt, 0);

        // Short ready dropout is filtered.
        iodelay_rdy = 1'b0;
        tick(3);
        iodelay_rdy = 1'b1;
        tick(2);
        check("short_loss_done", seq_done, 1);
        check("short_loss_rst_n", seq_rst_n, 1);

        // Four-cycle dropout triggers a re-request.
        iodelay_rdy = 1'b0;
        tick(4);
        check("loss_not_yet", loss_evt, 0);
        check("loss_not_yet_done", seq_done, 1);
        tick(1);
        iodelay_rdy = 1'b1;
        check("loss_evt_pulse", loss_evt, 1);
        check("loss_done_clr", seq_done, 0);
        check("loss_rst_n_low", seq_rst_n, 0);
        measure_low(len, evts);
        check("loss_pulse_len", len, 16);
        check("loss_evt_count", evts, 1);
        tick(1);
        check("loss_back_run", seq_done, 1);

        // Sequencer restarted externally: RUN -> WAIT, no pulse, fresh timeout.
        rst_pro = 1'b1;
        tick(1);
        check("restart_done_clr", seq_done, 0);
        check("restart_no_pulse", seq_rst_n, 1);
        check("restart_retry", retry_cnt, 0);
        tick(1023);
        check("restart_to_hold", seq_rst_n, 1);
        tick(1);
        check("restart_to_pulse", seq_rst_n, 0);
        check("restart_to_retry", retry_cnt, 1);
        measure_low(len, evts);
        check("retry_pulse_len", len, 16);

        // Board reset mid-WAIT acts without a clock edge.
        tick(500);
        check("mid_wait_retry", retry_cnt, 1);
        #10 sys_rst_n = 1'b0;
        #1;
        check("async_rst_n", seq_rst_n, 0);
        check("async_retry", retry_cnt, 0);
        @(negedge clk10m);
        sys_rst_n = 1'b1;
        measure_low(len, evts);
        check("async_pulse_len", len, 16);

        // Permanent rst_pro: three timeouts end in FAIL.
        for (int t = 1; t <= 3; t++) begin
            tick(1023);
            check("to_hold", seq_rst_n, 1);
            check("to_retry_before", retry_cnt, 32'(t - 1));
            tick(1);
            check("to_retry_after", retry_cnt, 32'(t));
            if (t < 3) begin
                check("to_pulse_start", seq_rst_n, 0);
                measure_low(len, evts);
                check("to_pulse_len", len, 16);
            end else begin
                check("fail_flag", seq_fail, 1);
                check("fail_rst_n", seq_rst_n, 1);
            end
        end

        // FAIL ignores everything except software request.
        rst_pro     = 1'b0;
        iodelay_rdy = 1'b0;
        tick(20);
        check("fail_hold", seq_fail, 1);
        check("fail_hold_rst_n", seq_rst_n, 1);
        check("fail_hold_done", seq_done, 0);
        check("fail_hold_retry", retry_cnt, 3);
        iodelay_rdy = 1'b1;
        sw_rst_req  = 1'b1;
        tick(1);
        sw_rst_req  = 1'b0;
        check("fail_clr", seq_fail, 0);
        check("fail_clr_retry", retry_cnt, 0);
        check("fail_clr_rst_n", seq_rst_n, 0);
        measure_low(len, evts);
        check("fail_clr_pulse_len", len, 16);
        tick(1);
        check("fail_clr_run", seq_done, 1);

        // Software request from RUN, re-requested at PULSE cnt=10.
        sw_rst_req = 1'b1;
        tick(1);
        sw_rst_req = 1'b0;
        check("sw_run_rst_n", seq_rst_n, 0);
        check("sw_run_done", seq_done, 0);
        tick(10);
        sw_rst_req = 1'b1;
        tick(1);
        sw_rst_req = 1'b0;
        measure_low(len, evts);
        check("sw_restart_len", len, 16);

        // Software request beats rst_pro=0 in WAIT.
        sw_rst_req = 1'b1;
        tick(1);
        sw_rst_req = 1'b0;
        check("sw_wait_prio_rst_n", seq_rst_n, 0);
        check("sw_wait_prio_done", seq_done, 0);
        measure_low(len, evts);
        check("sw_wait_pulse_len", len, 16);
        tick(2);
        check("final_run", seq_done, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
